// File: rtl/fp_div_pkg.sv
// Shared types and constants for the binary32 sequential divider.
// QB (quotient bits) grows by one guard bit when FP_DIV_ROUND_EN is defined.
package fp_div_pkg;

  // IDLE wait start | SETUP unpack/specials | DIVIDE iterate | NORM normalise/pack | DONE pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_e;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_MANT_W  = FP_FRAC_W + 1;
  localparam int REM_W      = FP_MANT_W + 1;
  localparam int EXP_CALC_W = 10;
  localparam int CNT_W      = 5;

`ifdef FP_DIV_ROUND_EN
  localparam int QB = 26;
`else
  localparam int QB = 25;
`endif

  localparam logic signed [EXP_CALC_W-1:0] EXP_MAX_S = EXP_CALC_W'(FP_EXP_MAX);

endpackage

// File: rtl/fp_mant_div.sv
// Radix-2 restoring mantissa divider: load seeds rem/div, each step retires one quotient bit.
module fp_mant_div
  import fp_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [FP_MANT_W-1:0] dividend_i,
  input  logic [FP_MANT_W-1:0] divisor_i,
  output logic [QB-1:0]        q_o,
  output logic [REM_W-1:0]     rem_o,
  output logic                 last_o
);

  logic [QB-1:0]        q_q, q_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [FP_MANT_W-1:0] div_q, div_d;
  logic [FP_MANT_W-1:0] diff;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    q_d   = q_q;
    rem_d = rem_q;
    div_d = div_q;
    cnt_d = cnt_q;
    // rem < 2*div always holds, so a taken subtraction fits in the mantissa width
    diff  = rem_q[FP_MANT_W-1:0] - div_q;
    if (load_i) begin
      q_d   = '0;
      rem_d = {1'b0, dividend_i};
      div_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (rem_q >= {1'b0, div_q}) begin
        q_d   = {q_q[QB-2:0], 1'b1};
        rem_d = {diff, 1'b0};
      end else begin
        q_d   = {q_q[QB-2:0], 1'b0};
        rem_d = {rem_q[REM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q_q   <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o    = q_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == CNT_W'(QB - 1));

endmodule

// File: rtl/fp_divider.sv
// Sequential binary32 divider with start/done handshake; denormals flush to zero.
// Define FP_DIV_ROUND_EN for round-to-nearest-even (default build truncates).
module fp_divider
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        overflow,
  output logic        infinity,
  output logic        NAN,
  output logic        divByZero
);

  state_e state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, quot_q, quot_d;
  logic        sign_q, sign_d;
  logic signed [EXP_CALC_W-1:0] exp_q, exp_d;
  logic        ovf_q, ovf_d, inf_q, inf_d, nan_q, nan_d, dbz_q, dbz_d;
  logic        div_load, div_step, div_last;
  logic [QB-1:0]    div_bits;
  logic [REM_W-1:0] div_rem;

  logic [FP_EXP_W-1:0]  ea, eb;
  logic [FP_FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab;

  assign ea      = a_q[FP_FRAC_W +: FP_EXP_W];
  assign eb      = b_q[FP_FRAC_W +: FP_EXP_W];
  assign fa      = a_q[FP_FRAC_W-1:0];
  assign fb      = b_q[FP_FRAC_W-1:0];
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == '1) && (fa == '0);
  assign b_inf   = (eb == '1) && (fb == '0);
  assign a_nan   = (ea == '1) && (fa != '0);
  assign b_nan   = (eb == '1) && (fb != '0);
  assign sign_ab = a_q[31] ^ b_q[31];

  fp_mant_div u_mant_div (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (div_load),
    .step_i    (div_step),
    .dividend_i({1'b1, fa}),
    .divisor_i ({1'b1, fb}),
    .q_o       (div_bits),
    .rem_o     (div_rem),
    .last_o    (div_last)
  );

  logic [QB-1:0]                q_norm;
  logic signed [EXP_CALC_W-1:0] exp_norm, exp_fin;
  logic [FP_MANT_W-1:0]         mant_fin;
  logic [31:0]                  norm_word;
  logic                         norm_ovf;
  logic                         unused_bits;

`ifdef FP_DIV_ROUND_EN
  logic               round_up;
  logic [FP_MANT_W:0] mant_rnd;
  // guard = q_norm[1], sticky = q_norm[0] plus any leftover remainder
  assign round_up = q_norm[1] & (q_norm[0] | (|div_rem) | q_norm[2]);
  assign mant_rnd = {1'b0, q_norm[QB-1 -: FP_MANT_W]} + {{FP_MANT_W{1'b0}}, round_up};
  assign unused_bits = mant_fin[FP_MANT_W-1];
`else
  assign unused_bits = ^{mant_fin[FP_MANT_W-1], q_norm[0], div_rem};
`endif

  always_comb begin
    q_norm   = div_bits;
    exp_norm = exp_q;
    if (!div_bits[QB-1]) begin
      q_norm   = div_bits << 1;
      exp_norm = exp_q - 10'sd1;
    end
`ifdef FP_DIV_ROUND_EN
    if (mant_rnd[FP_MANT_W]) begin
      mant_fin = mant_rnd[FP_MANT_W:1];
      exp_fin  = exp_norm + 10'sd1;
    end else begin
      mant_fin = mant_rnd[FP_MANT_W-1:0];
      exp_fin  = exp_norm;
    end
`else
    mant_fin = q_norm[QB-1 -: FP_MANT_W];
    exp_fin  = exp_norm;
`endif
    norm_ovf = 1'b0;
    if (exp_fin >= EXP_MAX_S) begin
      norm_word = {sign_q, 8'hFF, 23'b0};
      norm_ovf  = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      norm_word = {sign_q, 31'b0};
    end else begin
      norm_word = {sign_q, exp_fin[FP_EXP_W-1:0], mant_fin[FP_FRAC_W-1:0]};
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    quot_d   = quot_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    ovf_d    = ovf_q;
    inf_d    = inf_q;
    nan_d    = nan_q;
    dbz_d    = dbz_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ovf_d   = 1'b0;
          inf_d   = 1'b0;
          nan_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_DONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          quot_d = FP_QNAN;
          nan_d  = 1'b1;
        end else if (a_inf) begin
          quot_d = {sign_ab, 8'hFF, 23'b0};
          inf_d  = 1'b1;
        end else if (b_zero) begin
          quot_d = {sign_ab, 8'hFF, 23'b0};
          inf_d  = 1'b1;
          dbz_d  = 1'b1;
        end else if (a_zero || b_inf) begin
          quot_d = {sign_ab, 31'b0};
        end else begin
          sign_d   = sign_ab;
          exp_d    = EXP_CALC_W'(ea) - EXP_CALC_W'(eb) + EXP_CALC_W'(FP_BIAS);
          div_load = 1'b1;
          state_d  = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        div_step = 1'b1;
        if (div_last) state_d = S_NORM;
      end
      S_NORM: begin
        quot_d  = norm_word;
        ovf_d   = norm_ovf;
        inf_d   = norm_ovf;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign overflow  = ovf_q;
  assign infinity  = inf_q;
  assign NAN       = nan_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: hand-computed quotients, flags, latency and reset behaviour.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, overflow, infinity, NAN, divByZero;
  logic [31:0] quotient;
  logic [3:0]  flg;
  int          checks = 0;
  int          errors = 0;

`ifdef FP_DIV_ROUND_EN
  localparam int          LAT_NORM = 28;
  localparam logic [31:0] Q_THIRD  = 32'h3EAA_AAAB;
  localparam logic [31:0] Q_65_3   = 32'h400A_AAAB;
`else
  localparam int          LAT_NORM = 27;
  localparam logic [31:0] Q_THIRD  = 32'h3EAA_AAAA;
  localparam logic [31:0] Q_65_3   = 32'h400A_AAAA;
`endif
  localparam int LAT_SPECIAL = 1;

  fp_divider dut (
    .clk      (clk),
    .resetN   (resetN),
    .a        (a),
    .b        (b),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .overflow (overflow),
    .infinity (infinity),
    .NAN      (NAN),
    .divByZero(divByZero)
  );

  assign flg = {overflow, infinity, NAN, divByZero};

  always #5 clk = ~clk;

  // lat = number of edges after the accepting edge until done is seen (100 = timed out)
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    int guard_n = 0;
    @(negedge clk);
    while (busy && guard_n < 100) begin
      @(negedge clk);
      guard_n++;
    end
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quot: got %h expected 00000000", quotient); end
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flg); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'h4570_1440, 32'h4234_8000, lat);
    checks++; if (quotient !== 32'h42AA_4000) begin errors++; $display("FAIL basic_quot: got %h expected 42aa4000", quotient); end
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL basic_flags: got %b expected 0000", flg); end
    checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT_NORM); end
  endtask

  task automatic test_sign_and_round();
    int lat;
    run_op(32'h4267_0000, 32'hC128_0000, lat);
    checks++; if (quotient !== 32'hC0B0_0000) begin errors++; $display("FAIL neg_quot: got %h expected c0b00000", quotient); end
    checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL neg_latency: got %0d expected %0d", lat, LAT_NORM); end
    run_op(32'h3F80_0000, 32'h4040_0000, lat);
    checks++; if (quotient !== Q_THIRD) begin errors++; $display("FAIL third_quot: got %h expected %h", quotient, Q_THIRD); end
  endtask

  task automatic test_specials();
    int lat;
    run_op(32'h40A0_0000, 32'h0000_0000, lat);
    checks++; if (quotient !== 32'h7F80_0000) begin errors++; $display("FAIL divzero_quot: got %h expected 7f800000", quotient); end
    checks++; if (flg !== 4'b0101) begin errors++; $display("FAIL divzero_flags: got %b expected 0101", flg); end
    checks++; if (lat !== LAT_SPECIAL) begin errors++; $display("FAIL divzero_latency: got %0d expected %0d", lat, LAT_SPECIAL); end
    run_op(32'h0000_0000, 32'h8000_0000, lat);
    checks++; if (quotient !== 32'h7FC0_0000) begin errors++; $display("FAIL zz_quot: got %h expected 7fc00000", quotient); end
    checks++; if (flg !== 4'b0010) begin errors++; $display("FAIL zz_flags: got %b expected 0010", flg); end
    checks++; if (lat !== LAT_SPECIAL) begin errors++; $display("FAIL zz_latency: got %0d expected %0d", lat, LAT_SPECIAL); end
    run_op(32'hFF80_0000, 32'h4000_0000, lat);
    checks++; if (quotient !== 32'hFF80_0000) begin errors++; $display("FAIL inf_fin_quot: got %h expected ff800000", quotient); end
    checks++; if (flg !== 4'b0100) begin errors++; $display("FAIL inf_fin_flags: got %b expected 0100", flg); end
    run_op(32'h4000_0000, 32'hFF80_0000, lat);
    checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL fin_inf_quot: got %h expected 80000000", quotient); end
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL fin_inf_flags: got %b expected 0000", flg); end
    run_op(32'h7FC0_0001, 32'h3F80_0000, lat);
    checks++; if (quotient !== 32'h7FC0_0000 || flg !== 4'b0010) begin errors++; $display("FAIL nan_in: got %h/%b expected 7fc00000/0010", quotient, flg); end
  endtask

  task automatic test_range();
    int lat;
    run_op(32'h0080_0000, 32'h4000_0000, lat);
    checks++; if (quotient !== 32'h0000_0000) begin errors++; $display("FAIL flush_quot: got %h expected 00000000", quotient); end
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL flush_flags: got %b expected 0000", flg); end
    run_op(32'h7F00_0000, 32'h3F00_0000, lat);
    checks++; if (quotient !== 32'h7F80_0000) begin errors++; $display("FAIL ovf_quot: got %h expected 7f800000", quotient); end
    checks++; if (flg !== 4'b1100) begin errors++; $display("FAIL ovf_flags: got %b expected 1100", flg); end
  endtask

  task automatic test_mid_reset();
    int lat;
    int done_cnt = 0;
    @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL midrst_quot: got %h expected 00000000", quotient); end
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", flg); end
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt); end
    run_op(32'h40D0_0000, 32'h4040_0000, lat);
    checks++; if (quotient !== Q_65_3) begin errors++; $display("FAIL post_rst_quot: got %h expected %h", quotient, Q_65_3); end
    checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, LAT_NORM); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int done_cnt = 0;
    logic [31:0] q_cap = '0;
    logic [3:0]  f_cap = '1;
    @(negedge clk);
    while (busy) @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 32'h40A0_0000;
    b = 32'h0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        q_cap = quotient;
        f_cap = flg;
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    checks++; if (q_cap !== Q_THIRD) begin errors++; $display("FAIL ignore_quot: got %h expected %h", q_cap, Q_THIRD); end
    checks++; if (f_cap !== 4'b0000) begin errors++; $display("FAIL ignore_flags: got %b expected 0000", f_cap); end
    run_op(32'h4267_0000, 32'hC128_0000, lat);
    run_op(32'h4570_1440, 32'h4234_8000, lat);
    checks++; if (quotient !== 32'h42AA_4000) begin errors++; $display("FAIL b2b_quot: got %h expected 42aa4000", quotient); end
    checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT_NORM); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_and_round();
    test_specials();
    test_range();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
